pipeline_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Drives the enable input of PC, IF_ID, ID_EX, EX_MEM and MEM_WB, plus bubble/flush strobes.
- Detects load-use hazards, squashes wrong-path instructions on a taken branch, and freezes the pipe while a multi-cycle data-memory access is pending.
- Logic is on the posedge; the pipeline registers sample on the negedge, so outputs are settled half a cycle before the registers capture them.

---
 rtl/pipe_ctrl_pkg.sv | 86 ++++++++
 rtl/pipeline_ctrl_hazard_detect.sv | 16 +
 rtl/pipeline_ctrl.sv | 128 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the MIPS pipeline stall/flush sequencer.
// Enables are active-high "hold"; flushes are active-high "load a bubble".
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic       EN_LOAD  = 1'b0;
  localparam logic       EN_HOLD  = 1'b1;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_wb_flush;
  } ctrl_t;

  // Free-running pipe: every stage loads, no bubbles.
  localparam ctrl_t CTRL_RUN = '{
    pc_en:       EN_LOAD,
    if_id_en:    EN_LOAD,
    id_ex_en:    EN_LOAD,
    ex_mem_en:   EN_LOAD,
    mem_wb_en:   EN_LOAD,
    if_id_flush: 1'b0,
    id_ex_flush: 1'b0,
    mem_wb_flush: 1'b0
  };

  // Everything up to EX/MEM frozen; WB receives bubbles while MEM is busy.
  localparam ctrl_t CTRL_FREEZE = '{
    pc_en:       EN_HOLD,
    if_id_en:    EN_HOLD,
    id_ex_en:    EN_HOLD,
    ex_mem_en:   EN_HOLD,
    mem_wb_en:   EN_LOAD,
    if_id_flush: 1'b0,
    id_ex_flush: 1'b0,
    mem_wb_flush: 1'b1
  };

  // Taken branch: squash the two wrong-path instructions, PC loads the target.
  localparam ctrl_t CTRL_BRANCH = '{
    pc_en:       EN_LOAD,
    if_id_en:    EN_LOAD,
    id_ex_en:    EN_LOAD,
    ex_mem_en:   EN_LOAD,
    mem_wb_en:   EN_LOAD,
    if_id_flush: 1'b1,
    id_ex_flush: 1'b1,
    mem_wb_flush: 1'b0
  };

  // Load-use: hold the dependent instruction in ID, insert one bubble into EX.
  localparam ctrl_t CTRL_LOAD_USE = '{
    pc_en:       EN_HOLD,
    if_id_en:    EN_HOLD,
    id_ex_en:    EN_LOAD,
    ex_mem_en:   EN_LOAD,
    mem_wb_en:   EN_LOAD,
    if_id_flush: 1'b0,
    id_ex_flush: 1'b1,
    mem_wb_flush: 1'b0
  };

  // Reset: hold every register and force bubbles everywhere.
  localparam ctrl_t CTRL_RESET = '{
    pc_en:       EN_HOLD,
    if_id_en:    EN_HOLD,
    id_ex_en:    EN_HOLD,
    ex_mem_en:   EN_HOLD,
    mem_wb_en:   EN_HOLD,
    if_id_flush: 1'b1,
    id_ex_flush: 1'b1,
    mem_wb_flush: 1'b1
  };

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational load-use detector: the load in EX writes a register the
// instruction in ID reads. Writes to $0 are architecturally discarded.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] ID_rs,
  input  logic [4:0] ID_rt,
  input  logic [4:0] EX_rt,
  input  logic       EX_mem_read,
  output logic       load_use
);

  assign load_use = EX_mem_read && (EX_rt != REG_ZERO) &&
                    ((EX_rt == ID_rs) || (EX_rt == ID_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipe (Mealy outputs, posedge state).
// Optional macro PIPE_PERF_EN adds a saturating stall-cycle counter.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic [4:0]  EX_rt,
  input  logic        EX_mem_read,
  input  logic        branch_taken,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic        PC_enable,
  output logic        IF_ID_enable,
  output logic        ID_EX_enable,
  output logic        EX_MEM_enable,
  output logic        MEM_WB_enable,
  output logic        IF_ID_flush,
  output logic        ID_EX_flush,
  output logic        MEM_WB_flush,
  output logic        mem_err,
  output logic [31:0] stall_cycles
);

  state_t           state, next_state;
  logic [CNT_W-1:0] wait_cnt, next_cnt;
  logic             load_use;
  logic             mem_err_c;
  ctrl_t            ctrl;

  hazard_detect u_hazard (
    .ID_rs      (ID_rs),
    .ID_rt      (ID_rt),
    .EX_rt      (EX_rt),
    .EX_mem_read(EX_mem_read),
    .load_use   (load_use)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= next_state;
      wait_cnt <= next_cnt;
    end
  end

  always_comb begin
    ctrl       = CTRL_RUN;
    next_state = state;
    next_cnt   = wait_cnt;
    mem_err_c  = 1'b0;
    if (rst) begin
      ctrl = CTRL_RESET;
    end else begin
      unique case (state)
        RUN: begin
          // Memory stall outranks branch flush, which outranks load-use.
          if (mem_req && !mem_ack) begin
            ctrl       = CTRL_FREEZE;
            next_state = MEM_WAIT;
            next_cnt   = CNT_W'(1);
          end else if (branch_taken) begin
            ctrl = CTRL_BRANCH;
          end else if (load_use) begin
            ctrl = CTRL_LOAD_USE;
          end
        end
        MEM_WAIT: begin
          // EX is frozen here, so branch and hazard inputs are stale.
          if (mem_ack) begin
            next_state = RUN;
            next_cnt   = '0;
          end else begin
            ctrl = CTRL_FREEZE;
            if (wait_cnt == CNT_W'(MEM_TIMEOUT)) begin
              next_state = ERROR;
            end else begin
              next_cnt = wait_cnt + CNT_W'(1);
            end
          end
        end
        ERROR: begin
          ctrl      = CTRL_FREEZE;
          mem_err_c = 1'b1;
        end
        default: begin
          next_state = RUN;
          next_cnt   = '0;
        end
      endcase
    end
  end

  assign PC_enable     = ctrl.pc_en;
  assign IF_ID_enable  = ctrl.if_id_en;
  assign ID_EX_enable  = ctrl.id_ex_en;
  assign EX_MEM_enable = ctrl.ex_mem_en;
  assign MEM_WB_enable = ctrl.mem_wb_en;
  assign IF_ID_flush   = ctrl.if_id_flush;
  assign ID_EX_flush   = ctrl.id_ex_flush;
  assign MEM_WB_flush  = ctrl.mem_wb_flush;
  assign mem_err       = mem_err_c;

`ifdef PIPE_PERF_EN
  logic [31:0] stall_q;

  // A held PC marks a lost issue slot: load-use, memory wait or error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if ((ctrl.pc_en == EN_HOLD) && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized self-checking bench for pipeline_ctrl with directed scenarios
// and a cycle-level reference model of the stall/flush rules.
module tb_pipeline_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ID_rs, ID_rt, EX_rt;
  logic        EX_mem_read, branch_taken, mem_req, mem_ack;
  logic        PC_enable, IF_ID_enable, ID_EX_enable, EX_MEM_enable, MEM_WB_enable;
  logic        IF_ID_flush, ID_EX_flush, MEM_WB_flush, mem_err;
  logic [31:0] stall_cycles;

  int     n_tests = 0;
  int     n_fail  = 0;
  int     m_wait  = 0;
  bit     m_err   = 1'b0;
  longint m_stall = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(7)) dut (
    .clk          (clk),
    .rst          (rst),
    .ID_rs        (ID_rs),
    .ID_rt        (ID_rt),
    .EX_rt        (EX_rt),
    .EX_mem_read  (EX_mem_read),
    .branch_taken (branch_taken),
    .mem_req      (mem_req),
    .mem_ack      (mem_ack),
    .PC_enable    (PC_enable),
    .IF_ID_enable (IF_ID_enable),
    .ID_EX_enable (ID_EX_enable),
    .EX_MEM_enable(EX_MEM_enable),
    .MEM_WB_enable(MEM_WB_enable),
    .IF_ID_flush  (IF_ID_flush),
    .ID_EX_flush  (ID_EX_flush),
    .MEM_WB_flush (MEM_WB_flush),
    .mem_err      (mem_err),
    .stall_cycles (stall_cycles)
  );

  wire [8:0] dut_out = {mem_err, PC_enable, IF_ID_enable, ID_EX_enable, EX_MEM_enable,
                        MEM_WB_enable, IF_ID_flush, ID_EX_flush, MEM_WB_flush};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected {mem_err, pc, if_id, id_ex, ex_mem, mem_wb, if_id_f, id_ex_f, mem_wb_f}.
  function automatic logic [8:0] expect_out();
    logic       lu;
    logic [7:0] freeze;
    freeze = 8'b11110_001;
    lu = EX_mem_read && (EX_rt != 5'd0) && ((EX_rt == ID_rs) || (EX_rt == ID_rt));
    if (rst)                   return 9'b0_11111_111;
    if (m_err)                 return {1'b1, freeze};
    if (m_wait > 0)            return mem_ack ? 9'd0 : {1'b0, freeze};
    if (mem_req && !mem_ack)   return {1'b0, freeze};
    if (branch_taken)          return 9'b0_00000_110;
    if (lu)                    return 9'b0_11000_010;
    return 9'd0;
  endfunction

  task automatic model_reset();
    m_wait  = 0;
    m_err   = 1'b0;
    m_stall = 0;
  endtask

  task automatic model_clock();
    logic [8:0] e;
    e = expect_out();
`ifdef PIPE_PERF_EN
    if (e[7] && m_stall < 64'hFFFF_FFFF) m_stall++;
`endif
    if (m_err) begin
      m_err = 1'b1;
    end else if (m_wait > 0) begin
      if (mem_ack)           m_wait = 0;
      else if (m_wait == TO) begin m_err = 1'b1; m_wait = 0; end
      else                   m_wait++;
    end else if (mem_req && !mem_ack) begin
      m_wait = 1;
    end
  endtask

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] ert,
                        input logic mr, input logic br, input logic req, input logic ack);
    ID_rs = rs; ID_rt = rt; EX_rt = ert;
    EX_mem_read = mr; branch_taken = br; mem_req = req; mem_ack = ack;
  endtask

  // Called 1ns after a posedge; compares mid-cycle, then advances one clock.
  task automatic cycle(input string tag);
    #4;
    check(tag, {55'd0, dut_out}, {55'd0, expect_out()});
    @(posedge clk);
    model_clock();
    #1;
    check({tag, "_cnt"}, {32'd0, stall_cycles}, m_stall);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    model_reset();
    #1;
    check(tag, {55'd0, dut_out}, {55'd0, expect_out()});
    check({tag, "_cnt"}, {32'd0, stall_cycles}, m_stall);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [4:0] pool [4];
    pool[0] = 5'd0; pool[1] = 5'd8; pool[2] = 5'd9; pool[3] = 5'd3;
    rst = 1'b1;
    model_reset();
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check("reset_out", {55'd0, dut_out}, {55'd0, expect_out()});
    check("reset_cnt", {32'd0, stall_cycles}, 64'd0);
    rst = 1'b0;

    set_in(5'd8, 5'd1, 5'd8, 1, 0, 0, 0); cycle("load_use");
    set_in(5'd8, 5'd1, 5'd2, 0, 0, 0, 0); cycle("load_use_after");
    set_in(5'd0, 5'd1, 5'd0, 1, 0, 0, 0); cycle("load_r0");
    set_in(5'd3, 5'd4, 5'd9, 1, 0, 0, 0); cycle("no_match");
    set_in(5'd2, 5'd8, 5'd8, 1, 1, 0, 0); cycle("branch_vs_lu");

    set_in(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cycle("mem_wait");
    set_in(0, 0, 0, 0, 0, 1, 1); cycle("mem_ack");
    set_in(0, 0, 0, 0, 0, 0, 0); cycle("mem_done");
    set_in(0, 0, 0, 0, 0, 1, 1); cycle("zero_wait");
    set_in(0, 0, 0, 0, 0, 0, 0); cycle("zero_wait_after");

    set_in(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < TO + 1; i++) cycle("timeout_wait");
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 0, 0, 0, 1, i[0]);
      cycle("error_hold");
    end
    do_reset("err_reset");
    set_in(0, 0, 0, 0, 0, 0, 0); cycle("after_err_reset");

    set_in(0, 0, 0, 0, 0, 1, 0);
    cycle("pre_async"); cycle("pre_async");
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("async_rst_out", {55'd0, dut_out}, {55'd0, expect_out()});
    check("async_rst_cnt", {32'd0, stall_cycles}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0); cycle("post_async");
    set_in(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < TO + 2; i++) cycle("post_async_timeout");
    do_reset("post_async_reset");

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        do_reset("rand_reset");
      end else begin
        set_in(pool[$urandom_range(0, 3)], pool[$urandom_range(0, 3)], pool[$urandom_range(0, 3)],
               logic'($urandom_range(0, 1)), logic'($urandom_range(0, 3) == 0),
               logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 2) == 0));
        cycle("random");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
